// File: rtl/nb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nb_pkg
//  Description : Shared constants and types for the neuron-buffer read path.
//                Row geometry, memory depth, skid FIFO sizing and the reader
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package nb_pkg;

    localparam int N          = 16;            // neurons per lane group
    localparam int TN         = 16;            // bits per neuron
    localparam int NXTN       = N * TN;        // row width in bits (256)
    localparam int ADDR       = 6;             // memory address width
    localparam int NUM_WORDS  = 64;            // memory depth
    localparam int LEN_W      = ADDR + 1;      // burst length width, 0..NUM_WORDS
    localparam int FIFO_DEPTH = 2;             // output skid FIFO entries
    localparam int CNT_W      = 2;             // holds 0..FIFO_DEPTH

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : nb_pkg
`default_nettype wire

// File: rtl/nb_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nb_skid_fifo
//  Description : Two-entry circular buffer holding captured memory rows until
//                the downstream stage accepts them. Push and pop may occur in
//                the same cycle, including when full.
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                i_push, i_data    write a row at the tail
//                i_pop             retire the head row
//                o_data            head row (all zeros after reset)
//                o_count           occupancy 0..FIFO_DEPTH
//                o_full, o_empty   occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module nb_skid_fifo
    import nb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [NXTN-1:0]  i_data,
    input  logic             i_pop,
    output logic [NXTN-1:0]  o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [NXTN-1:0]  r_mem [0:FIFO_DEPTH-1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Depth is two, so a single bit is enough for each pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {{(CNT_W-1){1'b0}}, i_push}
                               - {{(CNT_W-1){1'b0}}, i_pop};
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);

endmodule : nb_skid_fifo
`default_nettype wire

// File: rtl/nb_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nb_mem_reader
//  Description : Read-side sequencer for the 64 x 256-bit neuron buffer.
//                Accepts a burst (base, length), issues one registered read
//                address per cycle, captures the returned rows into a 2-entry
//                skid FIFO and streams them out with valid/ready.
//  Ports       : clk, rst_n              clock, asynchronous active-low reset
//                i_start                 burst command strobe
//                i_base_addr, i_len      first row and row count (0..64)
//                o_busy                  burst in progress
//                o_done                  one-cycle pulse after the last handshake
//                o_mem_addr, o_mem_wen   memory address (registered), WEN (high)
//                i_mem_data              memory Q
//                o_data, o_valid,i_ready output stream
//  Revision    : 1.0  initial release
// ============================================================================
module nb_mem_reader
    import nb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [ADDR-1:0]  i_base_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [ADDR-1:0]  o_mem_addr,
    output logic             o_mem_wen,
    input  logic [NXTN-1:0]  i_mem_data,
    output logic [NXTN-1:0]  o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    state_t           r_state, w_state_nxt;
    logic [ADDR-1:0]  r_addr_cnt, w_addr_cnt_nxt;
    logic [LEN_W-1:0] r_issue_cnt, w_issue_cnt_nxt;
    logic [ADDR-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic             r_inflight, w_inflight_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W:0]   w_occ_after;
    logic             w_credit;
    logic             w_issue;
    logic [ADDR-1:0]  w_addr_inc;

    // The memory's address register is o_mem_addr itself, so Q for a read
    // issued at one edge is valid during the following cycle and is captured
    // at the next edge.
    assign w_pop  = o_valid & i_ready;
    assign w_push = r_inflight & (~w_full | w_pop);

    nb_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (i_mem_data),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy once this cycle's pop retires and the in-flight read lands.
    // Issuing only while this stays below the depth keeps the FIFO from
    // overflowing even when the consumer stalls.
    assign w_occ_after = {1'b0, w_count}
                       + {{CNT_W{1'b0}}, r_inflight}
                       - {{CNT_W{1'b0}}, w_pop};
    assign w_credit    = (w_occ_after < (CNT_W+1)'(FIFO_DEPTH));
    assign w_issue     = (r_state == RUN) && (r_issue_cnt != '0) && w_credit;
    assign w_addr_inc  = (r_addr_cnt == ADDR'(NUM_WORDS - 1)) ? '0
                                                               : r_addr_cnt + ADDR'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr_cnt  <= '0;
            r_issue_cnt <= '0;
            r_mem_addr  <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_cnt  <= w_addr_cnt_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_inflight  <= w_inflight_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_cnt_nxt  = r_addr_cnt;
        w_issue_cnt_nxt = r_issue_cnt;
        w_mem_addr_nxt  = r_mem_addr;
        w_inflight_nxt  = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_addr_cnt_nxt  = i_base_addr;
                        w_issue_cnt_nxt = i_len;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = RUN;
                    end else begin
                        // Empty burst completes immediately.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_issue) begin
                    w_mem_addr_nxt  = r_addr_cnt;
                    w_inflight_nxt  = 1'b1;
                    w_addr_cnt_nxt  = w_addr_inc;
                    w_issue_cnt_nxt = r_issue_cnt - LEN_W'(1);
                    if (r_issue_cnt == LEN_W'(1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Done is raised at the same edge as the final handshake.
                if (w_occ_after == '0) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_wen  = 1'b1;
    assign o_valid    = ~w_empty;

endmodule : nb_mem_reader
`default_nettype wire

// File: tb/tb_nb_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nb_mem_reader
//  Description : Directed self-checking bench for nb_mem_reader. A behavioural
//                memory returns a distinct pattern per address; every stream
//                beat is compared against the row expected for its position.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nb_mem_reader;
    import nb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [ADDR-1:0]  i_base_addr = '0;
    logic [LEN_W-1:0] i_len = '0;
    logic             o_busy;
    logic             o_done;
    logic [ADDR-1:0]  o_mem_addr;
    logic             o_mem_wen;
    logic [NXTN-1:0]  i_mem_data;
    logic [NXTN-1:0]  o_data;
    logic             o_valid;
    logic             i_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nb_mem_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wen   (o_mem_wen),
        .i_mem_data  (i_mem_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    // Row content for an address: distinct per address, replicated per word.
    function automatic logic [NXTN-1:0] row_of(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(a & 63) | (32'(a & 63) << 8);
        return {8{w}};
    endfunction

    // The memory's address register is o_mem_addr, so Q follows it directly.
    assign i_mem_data = row_of(int'(o_mem_addr));

    task automatic check(input string tag, input logic [NXTN-1:0] got,
                         input logic [NXTN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int base, input int len);
        i_start     = 1'b1;
        i_base_addr = ADDR'(base);
        i_len       = LEN_W'(len);
    endtask

    // Runs one burst whose start is already driven. k counts edges from the
    // edge that samples the start. rmode 0: ready always high; rmode 1:
    // ready pattern 1,0,0 repeating. mid: pulse a second start during RUN.
    task automatic run_burst(input int base, input int len, input int rmode,
                             input bit mid);
        int              idx;
        int              first_v;
        int              done_k;
        bit              prev_stall;
        logic [NXTN-1:0] prev_data;
        idx        = 0;
        first_v    = -1;
        done_k     = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (k == 0) i_start = 1'b0;
            if (mid && k == 2) drive_start(50, 2);
            if (mid && k == 3) i_start = 1'b0;
            check("fifo_over_2", (dut.u_fifo.o_count > 2), 0);
            if (k == 1 && len > 0) check("busy_in_burst", o_busy, 1);
            if (rmode == 0 && k >= 1 && k <= len)
                check("mem_addr_seq", o_mem_addr, (base + k - 1) % 64);
            if (prev_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, prev_data);
            end
            if (o_valid && first_v < 0) first_v = k;
            if (o_done) begin
                done_k = k;
                check("busy_at_done", o_busy, 0);
                check("valid_at_done", o_valid, 0);
                break;
            end
            i_ready = (rmode == 0) ? 1'b1 : (k % 3 == 0);
            if (o_valid && i_ready) begin
                if (idx < len) check("row_data", o_data, row_of((base + idx) % 64));
                else           check("extra_row", 1, 0);
                idx++;
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
        end
        i_ready = 1'b1;
        check("rows_delivered", idx, len);
        check("done_seen", (done_k >= 0), 1);
        if (rmode == 0) check("done_edge", done_k, (len == 0) ? 0 : len + 2);
        if (len == 0)   check("no_valid", (first_v < 0), 1);
        else if (rmode == 0) check("first_valid_edge", first_v, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  o_busy, 0);
        check("rst_done",  o_done, 0);
        check("rst_valid", o_valid, 0);
        check("rst_addr",  o_mem_addr, 0);
        check("rst_data",  o_data, 0);
        check("rst_wen",   o_mem_wen, 1);
        rst_n = 1'b1;
        tick();

        // Basic burst, ready held high.
        drive_start(5, 4);
        run_burst(5, 4, 0, 1'b0);
        tick();
        check("done_one_cycle", o_done, 0);
        check("idle_busy", o_busy, 0);

        // Address wrap 62,63,0,1.
        drive_start(62, 4);
        run_burst(62, 4, 0, 1'b0);
        tick();

        // Backpressure.
        drive_start(17, 6);
        run_burst(17, 6, 1, 1'b0);
        tick();

        // Zero-length burst.
        drive_start(9, 0);
        run_burst(9, 0, 0, 1'b0);
        tick();
        check("len0_done_cleared", o_done, 0);
        check("len0_busy", o_busy, 0);

        // Full-memory burst.
        drive_start(0, 64);
        run_burst(0, 64, 0, 1'b0);
        tick();

        // Start while busy is ignored.
        drive_start(30, 5);
        run_burst(30, 5, 0, 1'b1);
        tick();
        tick();
        check("mid_no_second_valid", o_valid, 0);
        check("mid_no_second_busy", o_busy, 0);

        // Reset at cycle 3 of a len=8 burst.
        drive_start(10, 8);
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  o_busy, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data",  o_data, 0);
        check("mid_rst_addr",  o_mem_addr, 0);
        tick();
        check("mid_rst_no_done", o_done, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_no_done", o_done, 0);
        check("post_rst_valid", o_valid, 0);

        // Back-to-back: new start in the done cycle.
        drive_start(20, 3);
        run_burst(20, 3, 0, 1'b0);
        drive_start(44, 3);
        run_burst(44, 3, 0, 1'b0);
        tick();
        check("final_idle_busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_nb_mem_reader
`default_nettype wire
